// File: rtl/i2c_target.sv
// i2c_target: write-only I2C responder; oversamples SCL/SDA, ACKs writes to ADDR, streams bytes out.
// Define I2C_TARGET_CTRL_DECODE_EN to enable SSD1306 control-byte decode (D/C# onto rx_is_data).
module i2c_target #(
  parameter logic [6:0] ADDR        = 7'h3C,
  parameter int          SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_is_data,
  output logic       busy
);
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_DATA, S_DATA_ACK, S_IGNORE
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_s, sda_s, scl_d, sda_d;
  logic                   start_c, stop_c, scl_rise, scl_fall;
  logic [3:0]             cnt;
  logic [7:0]             shreg;
  logic                   emit_pend;
`ifdef I2C_TARGET_CTRL_DECODE_EN
  logic                   ctrl_next, co_one;
`endif

  // Synchronizers and history run through reset so edge detection is valid as soon as it lifts.
  always_ff @(posedge clock) begin
    scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
    sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
    scl_d    <= scl_s;
    sda_d    <= sda_s;
  end

  assign scl_s    = scl_sync[SYNC_STAGES-1];
  assign sda_s    = sda_sync[SYNC_STAGES-1];
  assign start_c  = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_c   = scl_s & scl_d & ~sda_d & sda_s;
  assign scl_rise = scl_s & ~scl_d;
  assign scl_fall = ~scl_s & scl_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      shreg      <= 8'h00;
      emit_pend  <= 1'b0;
      sda_oe     <= 1'b0;
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      rx_is_data <= 1'b0;
      busy       <= 1'b0;
`ifdef I2C_TARGET_CTRL_DECODE_EN
      ctrl_next  <= 1'b0;
      co_one     <= 1'b0;
`endif
    end else begin
      rx_valid <= 1'b0;
      if (start_c) begin
        state     <= S_ADDR;
        cnt       <= 4'd0;
        sda_oe    <= 1'b0;
        emit_pend <= 1'b0;
      end else if (stop_c) begin
        state     <= S_IDLE;
        cnt       <= 4'd0;
        sda_oe    <= 1'b0;
        emit_pend <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          S_ADDR: if (scl_rise) begin
            shreg <= {shreg[6:0], sda_s};
            cnt   <= cnt + 4'd1;
            if (cnt == 4'd7) begin
              if ({shreg[6:0], sda_s} == {ADDR, 1'b0}) begin
                state <= S_ADDR_ACK;
                busy  <= 1'b1;
              end else begin
                state <= S_IGNORE;
                busy  <= 1'b0;
              end
            end
          end
          // First fall ends bit 7 and opens the ACK slot; the second fall closes it.
          S_ADDR_ACK, S_DATA_ACK: if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe <= 1'b1;
            end else begin
              sda_oe <= 1'b0;
              cnt    <= 4'd0;
              state  <= S_DATA;
`ifdef I2C_TARGET_CTRL_DECODE_EN
              if (state == S_ADDR_ACK) ctrl_next <= 1'b1;
`endif
            end
          end
          S_DATA: begin
            if (emit_pend) begin
              emit_pend <= 1'b0;
              rx_valid  <= 1'b1;
              rx_data   <= shreg;
            end else if (rx_valid) begin
              if (rx_ready) begin
                state <= S_DATA_ACK;
`ifdef I2C_TARGET_CTRL_DECODE_EN
                if (co_one) ctrl_next <= 1'b1;
`endif
              end else begin
                state <= S_IGNORE;
                busy  <= 1'b0;
              end
            end else if (scl_rise) begin
              shreg <= {shreg[6:0], sda_s};
              cnt   <= cnt + 4'd1;
              if (cnt == 4'd7) begin
`ifdef I2C_TARGET_CTRL_DECODE_EN
                if (ctrl_next) begin
                  ctrl_next  <= 1'b0;
                  rx_is_data <= shreg[5];
                  co_one     <= shreg[6];
                  state      <= S_DATA_ACK;
                end else
`endif
                emit_pend <= 1'b1;
              end
            end
          end
          S_IGNORE: sda_oe <= 1'b0;
          default:  state  <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: drives I2C write transfers and checks ACKs and strobes against a byte-level model.
module tb_i2c_target;
  localparam int Q = 5;

  logic       clock = 1'b0, reset = 1'b1;
  logic       scl_drv = 1'b1, sda_drv = 1'b1, rx_ready = 1'b0;
  logic       scl_in, sda_in, sda_oe, rx_valid, rx_is_data, busy;
  logic [7:0] rx_data;

  assign scl_in = scl_drv;
  assign sda_in = sda_drv & ~sda_oe;

  i2c_target dut (
    .clock(clock), .reset(reset), .scl_in(scl_in), .sda_in(sda_in),
    .sda_oe(sda_oe), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .rx_is_data(rx_is_data), .busy(busy)
  );

  always #5 clock = ~clock;

  int         checks = 0, errors = 0;
  logic [7:0] exp_q[$];
  logic       exp_dc_q[$];
  logic [7:0] log_d[16];
  logic       log_dc[16];
  int         nlog = 0;
  logic [7:0] tx_b[16];
  logic       tx_r[16];
  logic       exp_ack[16];
  logic       exp_aack;
  logic       m_is_data = 1'b0;
  logic       prev_vld = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every strobe must match the next byte the model predicted.
  always @(negedge clock) begin
    if (rx_valid) begin
      chk("strobe_width", prev_vld, 1'b0);
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_strobe: got %0h expected none", rx_data);
      end else begin
        chk("rx_data", rx_data, exp_q.pop_front());
        chk("rx_is_data", rx_is_data, exp_dc_q.pop_front());
      end
      if (nlog < 16) begin
        log_d[nlog] = rx_data; log_dc[nlog] = rx_is_data; nlog++;
      end
    end
    prev_vld = rx_valid;
  end

  // Byte-level model: n bytes fully delivered to target at address byte a.
  task automatic model_run(input logic [7:0] a, input int n);
    logic live;
`ifdef I2C_TARGET_CTRL_DECODE_EN
    logic ctrl, co1;
    ctrl = 1'b1; co1 = 1'b0;
`endif
    exp_aack = (a == 8'h78);
    live = exp_aack;
    for (int i = 0; i < n; i++) begin
      exp_ack[i] = 1'b0;
      if (live) begin
`ifdef I2C_TARGET_CTRL_DECODE_EN
        if (ctrl) begin
          m_is_data = tx_b[i][6]; co1 = tx_b[i][7]; ctrl = 1'b0; exp_ack[i] = 1'b1;
        end else begin
`endif
        exp_q.push_back(tx_b[i]);
        exp_dc_q.push_back(m_is_data);
        if (tx_r[i]) exp_ack[i] = 1'b1; else live = 1'b0;
`ifdef I2C_TARGET_CTRL_DECODE_EN
        if (tx_r[i] && co1) ctrl = 1'b1;
        end
`endif
      end
    end
  endtask

  task automatic wait_q(input int n);
    repeat (n * Q) @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clock);
    chk("reset_releases_sda", sda_oe, 1'b0);
    chk("reset_clears_busy", busy, 1'b0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    m_is_data = 1'b0;
  endtask

  task automatic bus_start();
    wait_q(1); sda_drv = 1'b1;
    wait_q(1); scl_drv = 1'b1;
    wait_q(2); sda_drv = 1'b0;
    wait_q(2); scl_drv = 1'b0;
  endtask

  task automatic bus_stop();
    wait_q(1); sda_drv = 1'b0;
    wait_q(1); scl_drv = 1'b1;
    wait_q(2); sda_drv = 1'b1;
    wait_q(2);
  endtask

  // Bit 8 is the ACK slot; ack is sampled mid-high before any reset in that slot.
  task automatic send_byte(input logic [7:0] b, input int nbits, input int rst_bit, output logic ack);
    ack = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      wait_q(1);
      sda_drv = (i < 8) ? b[7-i] : 1'b1;
      wait_q(1);
      scl_drv = 1'b1;
      wait_q(1);
      if (i == 8) ack = sda_oe;
      if (i == rst_bit) do_reset();
      wait_q(1);
      scl_drv = 1'b0;
    end
  endtask

  task automatic xfer(input logic [7:0] a, input int n, input int rst_byte, input int rst_bit);
    int   ndone;
    logic ack;
    ndone = (rst_byte < 0) ? n : ((rst_bit == 8) ? rst_byte + 1 : rst_byte);
    model_run(a, ndone);
    for (int i = ndone; i < n; i++) exp_ack[i] = 1'b0;
    nlog = 0;
    bus_start();
    send_byte(a, 9, -1, ack);
    chk("addr_ack", ack, exp_aack);
    chk("busy_after_addr", busy, exp_aack);
    for (int i = 0; i < n; i++) begin
      rx_ready = tx_r[i];
      send_byte(tx_b[i], 9, (i == rst_byte) ? rst_bit : -1, ack);
      chk($sformatf("byte%0d_ack", i), ack, exp_ack[i]);
    end
    bus_stop();
    repeat (8) @(negedge clock);
    chk("busy_after_stop", busy, 1'b0);
    chk("sda_oe_idle", sda_oe, 1'b0);
    chk("strobes_pending", exp_q.size(), 0);
  endtask

  task automatic load5();
    tx_b[0] = 8'h80; tx_b[1] = 8'hAE; tx_b[2] = 8'h40; tx_b[3] = 8'h01; tx_b[4] = 8'h02;
    for (int i = 0; i < 5; i++) tx_r[i] = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ack;
    repeat (4) @(negedge clock);
    chk("rst_sda_oe", sda_oe, 1'b0);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_rx_is_data", rx_is_data, 1'b0);
    chk("rst_busy", busy, 1'b0);
    reset = 1'b0;
    repeat (6) @(negedge clock);

    // 1: write 0xAA, 0x11
    tx_b[0] = 8'hAA; tx_r[0] = 1'b1; tx_b[1] = 8'h11; tx_r[1] = 1'b1;
    xfer(8'h78, 2, -1, 0);
`ifdef I2C_TARGET_CTRL_DECODE_EN
    chk("s1_count", nlog, 1);
    chk("s1_b0", log_d[0], 8'h11);
    chk("s1_dc0", log_dc[0], 1'b0);
`else
    chk("s1_count", nlog, 2);
    chk("s1_b0", log_d[0], 8'hAA);
    chk("s1_b1", log_d[1], 8'h11);
`endif

    // 2: wrong address 0x3D
    tx_b[0] = 8'h12; tx_r[0] = 1'b1;
    xfer(8'h7A, 1, -1, 0);
    chk("s2_count", nlog, 0);

    // 3: read request to 0x3C
    tx_b[0] = 8'h5A; tx_r[0] = 1'b1;
    xfer(8'h79, 1, -1, 0);
    chk("s3_count", nlog, 0);

    // 4: consumer refuses 0x22
    tx_b[0] = 8'h22; tx_r[0] = 1'b0; tx_b[1] = 8'h33; tx_r[1] = 1'b1;
    xfer(8'h78, 2, -1, 0);
`ifndef I2C_TARGET_CTRL_DECODE_EN
    chk("s4_count", nlog, 1);
    chk("s4_b0", log_d[0], 8'h22);
`endif

    // 5: repeated START mid-byte, then 0x55
    bus_start();
    send_byte(8'h78, 9, -1, ack);
    chk("s5_first_addr_ack", ack, 1'b1);
    send_byte(8'hF0, 4, -1, ack);
    tx_b[0] = 8'h55; tx_r[0] = 1'b1;
    xfer(8'h78, 1, -1, 0);
`ifndef I2C_TARGET_CTRL_DECODE_EN
    chk("s5_count", nlog, 1);
    chk("s5_b0", log_d[0], 8'h55);
`endif

    // 6: SSD1306-style stream
    load5();
    xfer(8'h78, 5, -1, 0);
`ifdef I2C_TARGET_CTRL_DECODE_EN
    chk("s6_count", nlog, 3);
    chk("s6_b0", log_d[0], 8'hAE);
    chk("s6_dc0", log_dc[0], 1'b0);
    chk("s6_b1", log_d[1], 8'h01);
    chk("s6_dc1", log_dc[1], 1'b1);
    chk("s6_b2", log_d[2], 8'h02);
    chk("s6_dc2", log_dc[2], 1'b1);
`else
    chk("s6_count", nlog, 5);
    chk("s6_b4", log_d[4], 8'h02);
`endif

    // 7: reset during bit 3 of 0x01
    load5();
    xfer(8'h78, 5, 3, 3);
`ifdef I2C_TARGET_CTRL_DECODE_EN
    chk("s7_count", nlog, 1);
`else
    chk("s7_count", nlog, 3);
`endif

    // 8: reset while the target drives the ACK of 0xAE
    load5();
    xfer(8'h78, 5, 1, 8);
    chk("s8_count", nlog, 2 - (`ifdef I2C_TARGET_CTRL_DECODE_EN 1 `else 0 `endif));

    // 9: a fresh transfer after reset works again
    tx_b[0] = 8'h3C; tx_r[0] = 1'b1;
    xfer(8'h78, 1, -1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
